// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of NUM_PORTS requesters and serialises its 1/2/4-byte access onto a byte-wide bus.
// Optional feature macro MEM_ARB_ROUND_ROBIN_EN selects round-robin grants; without it port 0 has fixed top priority.
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [2*NUM_PORTS-1:0]      req_len,
  input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [32*NUM_PORTS-1:0]     req_wdata,
  output logic [NUM_PORTS-1:0]        resp_done,
  output logic [31:0]                 resp_rdata,
  output logic                        busy,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [31:0]                 mem_a,
  output logic                        mem_wr,
  input  logic                        io_buffer_full
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, LAST, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    i_q, i_d;
  logic [1:0]    last_q, last_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [PW-1:0] win_q, win_d;

  logic          grant_any;
  logic [PW-1:0] grant_idx;
  logic [31:0]   cur_addr;
  logic          stall;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] ptr_q, ptr_d;
  int            rr_idx;

  // Scan downward so the requester nearest the pointer is the last one written and wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      rr_idx = int'(ptr_q) + k;
      if (rr_idx >= NUM_PORTS) rr_idx = rr_idx - NUM_PORTS;
      if (req_valid[PW'(rr_idx)]) begin
        grant_any = 1'b1;
        grant_idx = PW'(rr_idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && grant_any)
      ptr_d = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)      ptr_q <= '0;
    else if (rdy_in) ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_valid[PW'(k)]) begin
        grant_any = 1'b1;
        grant_idx = PW'(k);
      end
    end
  end
`endif

  assign cur_addr = addr_q + {30'b0, i_q};
  // Writes into the UART region wait while its transmit buffer is full.
  assign stall    = we_q & (cur_addr[17:16] == 2'b11) & io_buffer_full;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    win_d    = win_q;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d = XFER;
          win_d   = grant_idx;
          we_d    = req_we[grant_idx];
          addr_d  = 32'(req_addr[grant_idx*ADDR_W +: ADDR_W]);
          wdata_d = req_wdata[grant_idx*32 +: 32];
          rdata_d = '0;
          i_d     = '0;
          case (req_len[grant_idx*2 +: 2])
            2'b00:   last_d = 2'd0;
            2'b01:   last_d = 2'd1;
            default: last_d = 2'd3;
          endcase
        end
      end
      XFER: begin
        mem_a = cur_addr;
        if (we_q) begin
          case (i_q)
            2'd0:    mem_dout = wdata_q[7:0];
            2'd1:    mem_dout = wdata_q[15:8];
            2'd2:    mem_dout = wdata_q[23:16];
            default: mem_dout = wdata_q[31:24];
          endcase
          mem_wr = rdy_in & ~stall;
          if (!stall) begin
            if (i_q == last_q) state_d = DONE;
            else               i_d     = i_q + 2'd1;
          end
        end else begin
          // Read data trails its address by one cycle, so this edge captures the previous byte.
          if (i_q != 2'd0)
            rdata_d = rdata_q | ({24'b0, mem_din} << {i_q - 2'd1, 3'b000});
          if (i_q == last_q) state_d = LAST;
          else               i_d     = i_q + 2'd1;
        end
      end
      LAST: begin
        rdata_d = rdata_q | ({24'b0, mem_din} << {last_q, 3'b000});
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      i_q     <= '0;
      last_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      win_q   <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      i_q     <= i_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++)
      resp_done[k] = (state_q == DONE) && (win_q == PW'(k));
  end

  assign resp_rdata = (state_q == DONE && !we_q) ? rdata_q : 32'b0;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: transaction-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

  localparam int NP = 2;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            rdy_in;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_we;
  logic [2*NP-1:0] req_len;
  logic [32*NP-1:0] req_addr;
  logic [32*NP-1:0] req_wdata;
  logic [NP-1:0]   resp_done;
  logic [31:0]     resp_rdata;
  logic            busy;
  logic [7:0]      mem_din;
  logic [7:0]      mem_dout;
  logic [31:0]     mem_a;
  logic            mem_wr;
  logic            io_buffer_full;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_we(req_we), .req_len(req_len),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_done(resp_done), .resp_rdata(resp_rdata), .busy(busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  int nErr = 0;
  int nChecks = 0;
  bit checkEn = 1'b0;

  // External memory: sparse written bytes over an address-derived pattern.
  logic [7:0]  memOv [logic [31:0]];
  logic [7:0]  memDin = 8'h00;
  logic [31:0] sA = '0;
  logic        sWr = 1'b0;
  logic [7:0]  sDout = '0;
  assign mem_din = memDin;

  bit [NP-1:0] doneFlag = '0;
  bit [NP-1:0] pend = '0;

  // Reference model: position of the current transaction on its timeline.
  bit          mActive = 1'b0;
  int          mStep = 0;
  int          mN = 0;
  bit          mWe = 1'b0;
  int          mWin = 0;
  int          mPtr = 0;
  logic [31:0] mAddr = '0;
  logic [31:0] mWdata = '0;
  logic [31:0] mRword = '0;

  logic [31:0] eA, eRd, eDone, ba;
  logic [7:0]  eDout;
  logic        eWr, eBusy;

  function automatic logic [7:0] memRd(input logic [31:0] a);
    if (memOv.exists(a)) return memOv[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic bit stallAt(input logic [31:0] a, input logic full);
    return (a[17:16] == 2'b11) && full;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int p, input logic we, input logic [1:0] len,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_we[p]           = we;
    req_len[p*2 +: 2]   = len;
    req_addr[p*32 +: 32] = addr;
    req_wdata[p*32 +: 32] = wdata;
    req_valid[p]        = 1'b1;
  endtask

  task automatic dropPort(input int p);
    req_valid[p] = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk_in);
    #1;
  endtask

  // Memory shares the global pause, so its read register holds while rdy_in is low.
  initial forever begin
    @(posedge clk_in);
    if (checkEn && rdy_in) begin
      if (sWr) memOv[sA] = sDout;
      memDin <= memRd(sA);
    end
  end

  // Model advance at each edge, from the rules of the transaction timeline.
  initial forever begin
    @(posedge clk_in);
    if (rst_in) begin
      mActive = 1'b0;
      mPtr = 0;
    end else if (rdy_in) begin
      if (mActive) begin
        if (!(mWe && mStep < mN && stallAt(mAddr + 32'(mStep), io_buffer_full))) begin
          mStep++;
          if (mStep > (mWe ? mN : mN + 1)) mActive = 1'b0;
        end
      end else if (req_valid != '0) begin
        mWin = -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NP; k++)
          if (mWin < 0 && req_valid[(mPtr + k) % NP]) mWin = (mPtr + k) % NP;
        mPtr = (mWin + 1) % NP;
`else
        for (int k = 0; k < NP; k++)
          if (mWin < 0 && req_valid[k]) mWin = k;
`endif
        mWe    = req_we[mWin];
        mAddr  = req_addr[mWin*32 +: 32];
        mWdata = req_wdata[mWin*32 +: 32];
        case (req_len[mWin*2 +: 2])
          2'b00:   mN = 1;
          2'b01:   mN = 2;
          default: mN = 4;
        endcase
        mRword = '0;
        if (!mWe)
          for (int k = 0; k < mN; k++)
            mRword = mRword | (32'(memRd(mAddr + 32'(k))) << (8 * k));
        mStep = 0;
        mActive = 1'b1;
      end
    end
  end

  // Per-cycle compare of every output against the model, away from the active edge.
  initial forever begin
    @(negedge clk_in);
    sA = mem_a;
    sWr = mem_wr;
    sDout = mem_dout;
    for (int p = 0; p < NP; p++)
      if (resp_done[p] && (rdy_in || rst_in)) doneFlag[p] = 1'b1;
    if (checkEn) begin
      eBusy = mActive; eA = '0; eWr = 1'b0; eDout = '0; eDone = '0; eRd = '0;
      if (mActive) begin
        if (mStep < mN) begin
          ba = mAddr + 32'(mStep);
          eA = ba;
          if (mWe) begin
            eDout = 8'(mWdata >> (8 * mStep));
            eWr = rdy_in && !stallAt(ba, io_buffer_full);
          end
        end
        if (mStep == (mWe ? mN : mN + 1)) begin
          eDone = 32'(1) << mWin;
          eRd = mWe ? 32'h0 : mRword;
        end
      end
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("mem_a", mem_a, eA);
      checkOutput("mem_wr", 32'(mem_wr), 32'(eWr));
      checkOutput("mem_dout", 32'(mem_dout), 32'(eDout));
      checkOutput("resp_done", 32'(resp_done), eDone);
      checkOutput("resp_rdata", resp_rdata, eRd);
    end
  end

  logic [31:0] grants[$];
  int          expOrder[4];
  logic [31:0] rA;

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    req_valid = '0; req_we = '0; req_len = '0; req_addr = '0; req_wdata = '0;
    repeat (2) nextCycle();
    rst_in = 1'b0;
    checkEn = 1'b1;
    @(negedge clk_in);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(resp_done), 0);
    checkOutput("rst_rdata", resp_rdata, 0);
    checkOutput("rst_mem_a", mem_a, 0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 0);
    checkOutput("rst_mem_dout", 32'(mem_dout), 0);

    $display("[TB] word read port 0 at 0x100");
    memOv[32'h100] = 8'h11; memOv[32'h101] = 8'h22;
    memOv[32'h102] = 8'h33; memOv[32'h103] = 8'h44;
    applyStimulus(0, 1'b0, 2'b11, 32'h100, 32'h0);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      @(negedge clk_in);
      checkOutput("t1_addr", mem_a, 32'h100 + 32'(k));
    end
    repeat (2) nextCycle();
    @(negedge clk_in);
    checkOutput("t1_done", 32'(resp_done), 32'h1);
    checkOutput("t1_rdata", resp_rdata, 32'h44332211);
    nextCycle(); dropPort(0); nextCycle();

    $display("[TB] half write port 1 across 0x1FFFF");
    applyStimulus(1, 1'b1, 2'b01, 32'h1FFFF, 32'h0000BEEF);
    nextCycle(); @(negedge clk_in);
    checkOutput("t2_wr0", 32'(mem_wr), 1);
    checkOutput("t2_a0", mem_a, 32'h1FFFF);
    checkOutput("t2_d0", 32'(mem_dout), 32'hEF);
    nextCycle(); @(negedge clk_in);
    checkOutput("t2_wr1", 32'(mem_wr), 1);
    checkOutput("t2_a1", mem_a, 32'h20000);
    checkOutput("t2_d1", 32'(mem_dout), 32'hBE);
    nextCycle(); @(negedge clk_in);
    checkOutput("t2_done", 32'(resp_done), 32'h2);
    checkOutput("t2_rdata", resp_rdata, 32'h0);
    nextCycle(); dropPort(1); nextCycle();

    $display("[TB] UART byte write with buffer full");
    io_buffer_full = 1'b1;
    applyStimulus(0, 1'b1, 2'b00, 32'h30000, 32'h0000005A);
    for (int k = 0; k < 3; k++) begin
      nextCycle(); @(negedge clk_in);
      checkOutput("t3_stall_wr", 32'(mem_wr), 0);
    end
    nextCycle(); io_buffer_full = 1'b0; @(negedge clk_in);
    checkOutput("t3_wr", 32'(mem_wr), 1);
    checkOutput("t3_a", mem_a, 32'h30000);
    checkOutput("t3_d", 32'(mem_dout), 32'h5A);
    nextCycle(); @(negedge clk_in);
    checkOutput("t3_done", 32'(resp_done), 32'h1);
    nextCycle(); dropPort(0); nextCycle();

    $display("[TB] both ports requesting continuously");
    rst_in = 1'b1; nextCycle(); rst_in = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expOrder = '{0, 1, 0, 1};
`else
    expOrder = '{0, 0, 0, 0};
`endif
    applyStimulus(0, 1'b0, 2'b00, 32'h10, 32'h0);
    applyStimulus(1, 1'b0, 2'b00, 32'h20, 32'h0);
    grants.delete();
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      nextCycle(); @(negedge clk_in);
      if (resp_done != '0) grants.push_back(32'(resp_done));
    end
    checkOutput("t4_grant_count", grants.size(), 4);
    for (int k = 0; k < grants.size() && k < 4; k++)
      checkOutput("t4_grant", grants[k], 32'(1) << expOrder[k]);
    nextCycle(); req_valid = '0; nextCycle();

    $display("[TB] word read paused two cycles");
    applyStimulus(0, 1'b0, 2'b11, 32'h100, 32'h0);
    nextCycle();
    nextCycle(); rdy_in = 1'b0;
    nextCycle();
    nextCycle(); rdy_in = 1'b1;
    nextCycle();
    nextCycle(); @(negedge clk_in);
    checkOutput("t5_no_done_c6", 32'(resp_done), 0);
    nextCycle();
    nextCycle(); @(negedge clk_in);
    checkOutput("t5_done", 32'(resp_done), 32'h1);
    checkOutput("t5_rdata", resp_rdata, 32'h44332211);
    nextCycle(); dropPort(0); nextCycle();

    $display("[TB] reset during word write");
    applyStimulus(0, 1'b1, 2'b11, 32'h40, 32'hCAFEF00D);
    nextCycle();
    nextCycle(); rst_in = 1'b1; dropPort(0);
    nextCycle(); rst_in = 1'b0; @(negedge clk_in);
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_mem_a", mem_a, 0);
    checkOutput("t6_mem_wr", 32'(mem_wr), 0);
    checkOutput("t6_mem_dout", 32'(mem_dout), 0);
    checkOutput("t6_rdata", resp_rdata, 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t6_no_done", 32'(resp_done), 0);
      nextCycle(); @(negedge clk_in);
    end

    $display("[TB] randomized traffic");
    doneFlag = '0;
    pend = '0;
    for (int c = 0; c < 4000; c++) begin
      nextCycle();
      rdy_in = ($urandom_range(0, 9) != 0);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      rst_in = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < NP; p++) begin
        if (pend[p] && doneFlag[p]) begin
          pend[p] = 1'b0;
          doneFlag[p] = 1'b0;
          dropPort(p);
        end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          rA = $urandom;
          case ($urandom_range(0, 3))
            0: rA = rA;
            1: rA[17:16] = 2'b11;
            2: rA = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            default: rA = {rA[31:18], 2'b10, 16'hFFFE};
          endcase
          pend[p] = 1'b1;
          doneFlag[p] = 1'b0;
          applyStimulus(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rA, $urandom);
        end
      end
    end
    rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
    for (int c = 0; c < 200 && pend != '0; c++) begin
      nextCycle();
      for (int p = 0; p < NP; p++)
        if (pend[p] && doneFlag[p]) begin
          pend[p] = 1'b0;
          doneFlag[p] = 1'b0;
          dropPort(p);
        end
    end
    checkOutput("drain_pending", 32'(pend), 0);
    repeat (3) nextCycle();

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised memory controller between the pipeline's memory-facing stages (fetch, load/store and any future requesters) and the byte-wide external bus. It arbitrates among NUM_PORTS requesters and serialises each 1/2/4-byte access into byte cycles. It assembles read bytes into little-endian words and returns them with a one-cycle done pulse. It honours rdy_in pausing and stalls UART writes while io_buffer_full is high.

## Interface
- NUM_PORTS, 2: number of requester channels, 1..8.
- ADDR_W, 32: request address width; mem_a is always 32 bits, upper bits zero-filled.

- clk_in  input  1  system clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  low = freeze all state, drive mem_wr=0.
- req_valid  input  NUM_PORTS  per-port request; held high until that port's resp_done.
- req_we  input  NUM_PORTS  per-port 1=write, 0=read.
- req_len  input  2*NUM_PORTS  per-port size: 00 byte, 01 half, 11 word, 10 reserved and treated as word.
- req_addr  input  ADDR_W*NUM_PORTS  per-port start byte address.
- req_wdata  input  32*NUM_PORTS  per-port write data; byte 0 in bits 7:0.
- resp_done  output  NUM_PORTS  one-cycle pulse on the served port.
- resp_rdata  output  32  read data, zero-extended, valid only while resp_done is high.
- busy  output  1  high in any state other than IDLE.
- mem_din  input  8  external read byte; valid the cycle after its address.
- mem_dout  output  8  external write byte.
- mem_a  output  32  external byte address.
- mem_wr  output  1  1 = write this cycle.
- io_buffer_full  input  1  UART transmit buffer full.

## Operation
- FSM states are IDLE, XFER, LAST, DONE.
- In IDLE, the block samples req_valid. If any bit is set, it latches the winner's we/len/addr/wdata, sets byte counter i=0 and N=len+1 (len 10 gives N=4), then enters XFER.
- In XFER, mem_a=addr+i, with addition mod 2^32. Misaligned and region-crossing accesses are allowed.
- XFER write path:
  - mem_wr=1 and mem_dout=wdata byte i.
  - Stall condition: addr+i has bits [17:16]==2'b11 and io_buffer_full=1.
  - While stalled: mem_wr=0, i is held, no advance.
  - When i=N-1 and the block is not stalled, go to DONE.
- XFER read path:
  - mem_wr=0. On each edge with i>0, the block captures mem_din into byte i-1.
  - After the address of byte N-1 it enters LAST, which captures byte N-1 and goes to DONE. No io stall applies to reads.
- In DONE, resp_done[winner]=1 and resp_rdata = assembled bytes, upper bytes zero. For writes, resp_rdata=0. Next state is IDLE.
- There is no sign extension here; load sign handling stays in the mem stage.
- When not in XFER, mem_a=0, mem_dout=0 and mem_wr=0.

## Timing
- Reset values: state IDLE, busy=0, resp_done=0, resp_rdata=0, mem_a=0, mem_dout=0, mem_wr=0, RR pointer=0. Reset mid-transfer aborts it with no resp_done pulse.
- Cycle numbering: the request is accepted at edge E0, and C1 is the cycle after E0.
- Write: bytes go out in C1..CN and resp_done is high in C(N+1), i.e. N+1 cycles plus any io stall cycles.
- Read: addresses go out in C1..CN, bytes are captured at the ends of C2..C(N+1), and resp_done is high in C(N+2).
- After DONE there is always one IDLE cycle, so the earliest next acceptance is the edge ending that IDLE cycle. Back-to-back word reads from one port therefore occur every 7 cycles.
- A requester deasserting req_valid is only observed in IDLE. Dropping it mid-transfer is illegal.
- rdy_in=0 in any cycle:
  - State, counter, capture register and resp_done are held; a pending done pulse is delivered once rdy_in returns.
  - mem_wr=0 is forced.
  - For reads, the byte whose address was driven before the pause is re-addressed on resume, because mem_a holds and the capture is repeated.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. The search starts at pointer p, and on each grant p = winner+1 mod NUM_PORTS.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins, so port 0 (fetch) always beats data ports. The pointer register is not built.

## Test plan
- Word read, port 0, addr 0x100, memory bytes 11 22 33 44: mem_a is 0x100..0x103 in C1..C4, and in C6 resp_done=01 with resp_rdata=0x44332211.
- Half write, port 1, addr 0x1FFFF, wdata 0xBEEF: C1 writes EF to 0x1FFFF, C2 writes BE to 0x20000, and resp_done=10 in C3.
- Byte write to 0x30000 with io_buffer_full high for 3 cycles: mem_wr stays 0 for those 3 cycles, the write happens on the 4th cycle, and done follows one cycle later.
- Both ports request continuously with round robin enabled: grants alternate 0,1,0,1. With the macro undefined, port 0 is granted every time.
- Word read with rdy_in low for 2 cycles at C2: the result is identical to the unpaused case and done is delayed by 2 cycles.
- rst_in asserted in C2 of a word write: outputs are zero the next cycle, no resp_done is issued, busy=0 and the FSM is in IDLE.
